// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Data wins contention unless it won last time; halt blocks only new fetch grants.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   input  logic              hlt,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid
);

   typedef enum logic [1:0] {IDLE, D_BUSY, F_BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              last_grant_data_q, last_grant_data_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;

   logic data_pend, fetch_pend, grant_data, grant_fetch;

   always_comb begin
      data_pend   = d_rd | d_wr;
      fetch_pend  = if_req & ~hlt;
      // Round-robin tie-break: data loses only if it also won the previous grant
      grant_data  = data_pend & (~fetch_pend | ~last_grant_data_q);
      grant_fetch = fetch_pend & ~grant_data;

      state_d           = state_q;
      last_grant_data_d = last_grant_data_q;
      mem_en_d          = 1'b0;
      mem_wr_d          = mem_wr_q;
      mem_addr_d        = mem_addr_q;
      mem_wdata_d       = mem_wdata_q;
      if_rdata_d        = if_rdata_q;
      d_rdata_d         = d_rdata_q;
      if_done_d         = 1'b0;
      d_done_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d           = D_BUSY;
               last_grant_data_d = 1'b1;
               mem_en_d          = 1'b1;
               mem_wr_d          = d_wr;
               mem_addr_d        = d_addr;
               mem_wdata_d       = d_wdata;
            end else if (grant_fetch) begin
               state_d           = F_BUSY;
               last_grant_data_d = 1'b0;
               mem_en_d          = 1'b1;
               mem_wr_d          = 1'b0;
               mem_addr_d        = if_addr;
               mem_wdata_d       = '0;
            end
         end
         D_BUSY: begin
            if (mem_valid) begin
               state_d  = DONE;
               d_done_d = 1'b1;
               if (!mem_wr_q) d_rdata_d = mem_rdata;
            end
         end
         F_BUSY: begin
            if (mem_valid) begin
               state_d    = DONE;
               if_done_d  = 1'b1;
               if_rdata_d = mem_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         last_grant_data_q <= 1'b0;
         mem_en_q          <= 1'b0;
         mem_wr_q          <= 1'b0;
         mem_addr_q        <= '0;
         mem_wdata_q       <= '0;
         if_rdata_q        <= '0;
         d_rdata_q         <= '0;
         if_done_q         <= 1'b0;
         d_done_q          <= 1'b0;
      end else begin
         state_q           <= state_d;
         last_grant_data_q <= last_grant_data_d;
         mem_en_q          <= mem_en_d;
         mem_wr_q          <= mem_wr_d;
         mem_addr_q        <= mem_addr_d;
         mem_wdata_q       <= mem_wdata_d;
         if_rdata_q        <= if_rdata_d;
         d_rdata_q         <= d_rdata_d;
         if_done_q         <= if_done_d;
         d_done_q          <= d_done_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign if_stall  = if_req & ~if_done_q;
   assign d_stall   = (d_rd | d_wr) & ~d_done_q;

endmodule
